// File: rtl/scan_pkg.sv
// Shared types for the decoder scan sequencer.
// Optional SCAN_ONEHOT_EN output uses the onehot helper below.
package scan_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic {
        ST_IDLE,
        ST_DWELL
    } state_t;

    // Index 0 is the MSB position of the returned vector.
    function automatic logic [0:NUM_CH-1] onehot(input logic [SEL_W-1:0] code);
        logic [0:NUM_CH-1] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/decoder_scan_sequencer_next_chan_find.sv
// Combinational search for the next enabled channel above a code,
// optionally wrapping to the lowest enabled channel.
module next_chan_find
    import scan_pkg::*;
(
    input  logic [NUM_CH-1:0] i_mask,
    input  logic [SEL_W-1:0]  i_cur,
    input  logic              i_wrap_allow,
    output logic [SEL_W-1:0]  o_next,
    output logic              o_found,
    output logic              o_wrapped,
    output logic [SEL_W-1:0]  o_first
);

    logic [SEL_W-1:0] w_first;
    logic [SEL_W-1:0] w_hi;
    logic             w_hi_found;
    logic             w_any;

    // Descending scan: the last hit is the lowest qualifying index.
    always_comb begin
        w_first    = '0;
        w_hi       = '0;
        w_hi_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                w_first = SEL_W'(i);
            end
            if (i_mask[i] && (i > int'(i_cur))) begin
                w_hi       = SEL_W'(i);
                w_hi_found = 1'b1;
            end
        end
    end

    assign w_any     = |i_mask;
    assign o_first   = w_first;
    assign o_next    = w_hi_found ? w_hi : w_first;
    assign o_found   = w_hi_found | (i_wrap_allow & w_any);
    assign o_wrapped = ~w_hi_found & i_wrap_allow & w_any;

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Select-code sequencer feeding a 3-to-8 decoder A input.
// Define SCAN_ONEHOT_EN to add the registered sel_onehot output.
module decoder_scan_sequencer #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       cont,
    input  logic [DWELL_W-1:0]         dwell,
    input  logic [scan_pkg::NUM_CH-1:0] chan_mask,
    output logic [SEL_W-1:0]           sel_a,
    output logic                       sel_valid,
    output logic                       busy,
    output logic                       done,
    output logic                       wrap,
    output logic                       err
`ifdef SCAN_ONEHOT_EN
    ,
    output logic [0:scan_pkg::NUM_CH-1] sel_onehot
`endif
);

    import scan_pkg::*;

    state_t               r_state;
    logic [NUM_CH-1:0]    r_mask;
    logic [DWELL_W-1:0]   r_dwell;
    logic                 r_cont;
    logic [DWELL_W-1:0]   r_cnt;
    logic [SEL_W-1:0]     r_sel;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_wrap;
    logic                 r_err;

    logic [NUM_CH-1:0]    w_mask;
    logic [SEL_W-1:0]     w_next;
    logic                 w_found;
    logic                 w_wrapped;
    logic [SEL_W-1:0]     w_first;

    // One finder serves both start (live mask) and advance (latched mask).
    assign w_mask = (r_state == ST_IDLE) ? chan_mask : r_mask;

    next_chan_find u_find (
        .i_mask       (w_mask),
        .i_cur        (r_sel),
        .i_wrap_allow (r_cont),
        .o_next       (w_next),
        .o_found      (w_found),
        .o_wrapped    (w_wrapped),
        .o_first      (w_first)
    );

`ifdef SCAN_ONEHOT_EN
    logic [0:NUM_CH-1] r_oh;
    assign sel_onehot = r_oh;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
            r_dwell <= '0;
            r_cont  <= 1'b0;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
            r_err   <= 1'b0;
`ifdef SCAN_ONEHOT_EN
            r_oh    <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        if (chan_mask == '0) begin
                            r_err <= 1'b1;
                        end else begin
                            r_mask  <= chan_mask;
                            r_dwell <= dwell;
                            r_cont  <= cont;
                            r_cnt   <= dwell;
                            r_sel   <= w_first;
                            r_valid <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= ST_DWELL;
`ifdef SCAN_ONEHOT_EN
                            r_oh    <= onehot(w_first);
`endif
                        end
                    end
                end
                ST_DWELL: begin
                    if (stop) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
`ifdef SCAN_ONEHOT_EN
                        r_oh    <= '0;
`endif
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_found) begin
                        r_sel  <= w_next;
                        r_cnt  <= r_dwell;
                        r_wrap <= w_wrapped;
`ifdef SCAN_ONEHOT_EN
                        r_oh   <= onehot(w_next);
`endif
                    end else begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
`ifdef SCAN_ONEHOT_EN
                        r_oh    <= '0;
`endif
                    end
                end
            endcase
        end
    end

    assign sel_a     = r_sel;
    assign sel_valid = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign wrap      = r_wrap;
    assign err       = r_err;

endmodule

// File: doc/decoder_scan_sequencer.md
Name: decoder_scan_sequencer

Overview:
- Upstream feeder for the 3-to-8 decoder: generates the 3-bit select code that drives the decoder's A input.
- Steps through the enabled channels in ascending order and holds each code for a programmable dwell time.
- Supports a single sweep or continuous scanning, with a start/stop control handshake.

Parameters:
- SEL_W, 3, width of the select code; number of channels is 2**SEL_W = 8.
- DWELL_W, 8, width of the dwell-count input.

Ports:
- clk  input  1  sole clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  one-cycle request to begin a scan; sampled only in IDLE.
- stop  input  1  abort request; effective at the next edge in any state.
- cont  input  1  mode, latched at start: 0 = single sweep, 1 = continuous.
- dwell  input  DWELL_W  hold count, latched at start; each code is held for dwell+1 cycles.
- chan_mask  input  8  enable per channel (bit i enables code i), latched at start.
- sel_a  output  SEL_W  select code to the decoder A input; registered.
- sel_valid  output  1  high while sel_a carries a live code.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a single sweep completes.
- wrap  output  1  one-cycle pulse when a continuous scan wraps from its highest enabled code back to its lowest.
- err  output  1  one-cycle pulse when start is seen with chan_mask == 0.

Behaviour:
- Reset (rst_n low at an edge) forces: state IDLE, sel_a = 0, sel_valid = 0, busy = 0, done = 0, wrap = 0, err = 0, dwell counter = 0, latched mask/mode/dwell = 0.
- Reset mid-scan aborts immediately, with no done pulse.
- States: IDLE, DWELL.
- IDLE, start = 1, stop = 0, chan_mask != 0:
  - latch mask, dwell and cont;
  - at the same edge, set sel_a to the lowest enabled code, sel_valid = 1, counter = latched dwell;
  - go to DWELL.
  - First code is visible one cycle after start is sampled.
- IDLE, start = 1, chan_mask == 0: err pulses for 1 cycle; stay in IDLE.
- IDLE, start = 1 and stop = 1 together: stop wins; stay in IDLE, no err.
- DWELL, counter != 0: decrement; sel_a is held.
- DWELL, counter == 0: advance to the next enabled code above sel_a and reload the counter. If no higher code is enabled:
  - cont = 0: sel_valid = 0, done pulses 1 cycle, go to IDLE; sel_a keeps the last code.
  - cont = 1: sel_a = lowest enabled code, wrap pulses 1 cycle (same edge as the new code).
- Single enabled channel with cont = 1: sel_a is constant; wrap pulses every dwell+1 cycles.
- stop in DWELL: next edge sel_valid = 0, go to IDLE, no done.
  - stop takes priority over an advance or completion on the same edge.
- start while busy is ignored.
- Changes to chan_mask, dwell or cont while busy are ignored; the latched copies are used.
- Codes advance by mask search, not by +1. Search wraps 7 -> 0 only in cont mode.
- dwell = 0 means one cycle per code. dwell = 255 means 256 cycles.
- Done/wrap/err are registered pulses; never high for 2 consecutive cycles from a single event.

Optional Feature:
- Macro: SCAN_ONEHOT_EN.
- Defined: adds output sel_onehot [0:7], a registered one-hot form of sel_a. Index i (with 0 the MSB position) is high when sel_a == i and sel_valid = 1. All zero when sel_valid = 0 or in reset.
  - Bench compares it against the decoder's Y output in the same cycle.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package scan_pkg holds:
  - NUM_CH = 8 and SEL_W = 3;
  - state enum (ST_IDLE, ST_DWELL).
- Sub-module next_chan_find, purely combinational:
  - inputs: mask[7:0], current code, wrap_allow;
  - outputs: next code, found flag, wrapped flag, and a first_code output (lowest set bit).
  - Used by both the start path and the advance path.

Test Plan:
- Reset: rst_n low for 3 cycles mid-scan -> all outputs 0 at the next edge, busy = 0, no done.
- Single sweep, mask = 8'hFF, dwell = 0, cont = 0 -> sel_a = 0..7 on 8 consecutive cycles, then done 1 cycle after code 7, busy drops, sel_valid = 0.
- Sparse mask = 8'b1010_0100, dwell = 2, cont = 1 -> sel_a sequence 2, 5, 7, each held 3 cycles; wrap pulses with return to 2; stop asserted -> idle next edge, no done.
- mask = 0 with start -> err pulse 1 cycle, busy stays 0; start + stop together with a valid mask -> nothing happens.
- start re-asserted and mask changed during a scan -> ignored; sequence follows the latched mask.
- SCAN_ONEHOT_EN defined: sweep with mask = 8'hFF -> sel_onehot has exactly one set bit, matching the decoder output each cycle; all zero after done.
